// File: rtl/lcd_msg_writer.sv
// lcd_msg_writer
//   Drives an HD44780-compatible 16x2 character LCD over its 8-bit parallel bus.
//   The bus is write-only.
//   After the power-up wait it sends the init sequence 0x38, 0x0C, 0x06, 0x01.
//   It then rewrites both text lines whenever the display index changes.
//   Line 1 reads "TRAFFIC STATE: <L>".
//   Line 2 reads "PHASE <D>/8" padded with spaces.
//
// Ports
//   clk      system clock
//   rst      asynchronous reset, active-low
//   state2   display index from the upstream mapper (valid 1..8)
//   lcd_e    LCD enable strobe
//   lcd_rs   register select: 0 = command, 1 = data
//   lcd_rw   read/write select, tied low
//   lcd_data LCD data bus
//   ready    init sequence complete
//   busy     init or refresh sequence in progress
module lcd_msg_writer #(
   parameter int unsigned INIT_WAIT = 750000,
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned EN_CYC    = 12,
   parameter int unsigned CMD_WAIT  = 2000,
   parameter int unsigned CLR_WAIT  = 82000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] state2,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data,
   output logic       ready,
   output logic       busy
);

   localparam int unsigned MAX_A = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
   localparam int unsigned MAX_B = (CMD_WAIT > EN_CYC) ? CMD_WAIT : EN_CYC;
   localparam int unsigned MAX_C = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
   localparam int unsigned MAXW  = (MAX_A > MAX_C) ? MAX_A : MAX_C;
   localparam int unsigned CW    = $clog2(MAXW + 1);

   // Text templates.
   // The '?' positions are replaced by the letter/digit derived from the snapshot.
   localparam logic [8*16-1:0] LINE1 = "TRAFFIC STATE: ?";
   localparam logic [8*16-1:0] LINE2 = "PHASE ?/8       ";

   localparam logic [5:0] LAST_INIT  = 6'd3;
   localparam logic [5:0] LAST_WRITE = 6'd33;

   typedef enum logic [1:0] {ST_PWR, ST_INIT, ST_IDLE, ST_WRITE} top_t;
   typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

   top_t          top_q, top_d;
   phase_t        phase_q, phase_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [5:0]    idx_q, idx_d;
   logic [3:0]    snap_q, snap_d;
   logic [3:0]    shown_q, shown_d;
   logic [7:0]    data_q, data_d;
   logic          rs_q, rs_d;
   logic          e_q, e_d;
   logic          ready_q, ready_d;

   logic [CW-1:0] hold_len;
   logic [5:0]    nxt_idx;

   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      logic [7:0] c;
      case (i)
         2'd0:    c = 8'h38;
         2'd1:    c = 8'h0C;
         2'd2:    c = 8'h06;
         default: c = 8'h01;
      endcase
      return c;
   endfunction

   // Returns {rs, data} for byte i of a refresh, given the snapshot index s.
   function automatic logic [8:0] msg_byte(input logic [5:0] i, input logic [3:0] s);
      logic       ok;
      logic [7:0] l;
      logic [7:0] d;
      logic [8:0] b;
      ok = (s >= 4'd1) && (s <= 4'd8);
      l  = ok ? (8'h40 + {4'h0, s}) : 8'h3F;
      d  = ok ? (8'h30 + {4'h0, s}) : 8'h3F;
      if (i == 6'd0)
         b = {1'b0, 8'h80};
      else if (i <= 6'd15)
         b = {1'b1, LINE1[8*(16 - int'(i)) +: 8]};
      else if (i == 6'd16)
         b = {1'b1, l};
      else if (i == 6'd17)
         b = {1'b0, 8'hC0};
      else if (i == 6'd24)
         b = {1'b1, d};
      else if (i <= 6'd33)
         b = {1'b1, LINE2[8*(33 - int'(i)) +: 8]};
      else
         b = {1'b1, 8'h20};
      return b;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         top_q   <= ST_PWR;
         phase_q <= PH_SETUP;
         cnt_q   <= '0;
         idx_q   <= '0;
         snap_q  <= '0;
         shown_q <= '0;
         data_q  <= '0;
         rs_q    <= 1'b0;
         e_q     <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         top_q   <= top_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         shown_q <= shown_d;
         data_q  <= data_d;
         rs_q    <= rs_d;
         e_q     <= e_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      top_d    = top_q;
      phase_d  = phase_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      snap_d   = snap_q;
      shown_d  = shown_q;
      data_d   = data_q;
      rs_d     = rs_q;
      e_d      = 1'b0;
      ready_d  = ready_q;
      nxt_idx  = idx_q + 6'd1;
      // The Clear command needs the long post-strobe wait.
      // Every other byte uses the normal one.
      hold_len = (!rs_q && data_q == 8'h01) ? CW'(CLR_WAIT) : CW'(CMD_WAIT);

      case (top_q)
         ST_PWR: begin
            if (cnt_q == CW'(INIT_WAIT - 1)) begin
               top_d   = ST_INIT;
               phase_d = PH_SETUP;
               cnt_d   = '0;
               idx_d   = '0;
               rs_d    = 1'b0;
               data_d  = init_cmd(2'd0);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_IDLE: begin
            if (state2 != shown_q) begin
               snap_d         = state2;
               top_d          = ST_WRITE;
               phase_d        = PH_SETUP;
               cnt_d          = '0;
               idx_d          = '0;
               {rs_d, data_d} = msg_byte(6'd0, state2);
            end
         end

         ST_INIT, ST_WRITE: begin
            case (phase_q)
               PH_SETUP: begin
                  if (cnt_q == CW'(SETUP_CYC - 1)) begin
                     phase_d = PH_PULSE;
                     cnt_d   = '0;
                     e_d     = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end

               PH_PULSE: begin
                  if (cnt_q == CW'(EN_CYC - 1)) begin
                     phase_d = PH_HOLD;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                     e_d   = 1'b1;
                  end
               end

               PH_HOLD: begin
                  if (cnt_q == hold_len - CW'(1)) begin
                     cnt_d   = '0;
                     phase_d = PH_SETUP;
                     if (top_q == ST_INIT) begin
                        if (idx_q == LAST_INIT) begin
                           top_d   = ST_IDLE;
                           ready_d = 1'b1;
                        end else begin
                           idx_d  = nxt_idx;
                           data_d = init_cmd(nxt_idx[1:0]);
                        end
                     end else begin
                        if (idx_q == LAST_WRITE) begin
                           top_d   = ST_IDLE;
                           shown_d = snap_q;
                        end else begin
                           idx_d          = nxt_idx;
                           {rs_d, data_d} = msg_byte(nxt_idx, snap_q);
                        end
                     end
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end

               default: begin
                  phase_d = PH_SETUP;
                  cnt_d   = '0;
               end
            endcase
         end

         default: top_d = ST_PWR;
      endcase
   end

   assign lcd_e    = e_q;
   assign lcd_rs   = rs_q;
   assign lcd_rw   = 1'b0;
   assign lcd_data = data_q;
   assign ready    = ready_q;
   assign busy     = (top_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_msg_writer.sv
// tb_lcd_msg_writer
//   Self-checking bench for lcd_msg_writer, built with short timing parameters.
//   A bus monitor records every strobed byte and checks the bus timing.
//   Expected byte streams are built from the message text using strings.
module tb_lcd_msg_writer;

   localparam int unsigned INIT_WAIT = 10;
   localparam int unsigned SETUP_CYC = 1;
   localparam int unsigned EN_CYC    = 2;
   localparam int unsigned CMD_WAIT  = 3;
   localparam int unsigned CLR_WAIT  = 8;
   localparam int unsigned BYTE_CYC  = SETUP_CYC + EN_CYC + CMD_WAIT;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] state2 = 4'd0;
   logic       lcd_e, lcd_rs, lcd_rw, ready, busy;
   logic [7:0] lcd_data;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   logic [8:0] got[$];
   logic [8:0] want_q[$];
   logic [3:0] shown_m;

   // Bus monitor state.
   int         cyc       = 0;
   int         rise_cyc  = 0;
   int         prev_fall = -1;
   int         last_chg  = 0;
   int         prev_wait = 0;
   int         brun      = 0;
   int         last_busy = 0;
   logic       pulse_on  = 1'b0;
   logic [8:0] prev_bus  = '0;

   lcd_msg_writer #(
      .INIT_WAIT(INIT_WAIT),
      .SETUP_CYC(SETUP_CYC),
      .EN_CYC   (EN_CYC),
      .CMD_WAIT (CMD_WAIT),
      .CLR_WAIT (CLR_WAIT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .state2  (state2),
      .lcd_e   (lcd_e),
      .lcd_rs  (lcd_rs),
      .lcd_rw  (lcd_rw),
      .lcd_data(lcd_data),
      .ready   (ready),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act === want)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, want);
   endtask

   function automatic void push_init();
      want_q.push_back(9'h038);
      want_q.push_back(9'h00C);
      want_q.push_back(9'h006);
      want_q.push_back(9'h001);
   endfunction

   function automatic void push_msg(input logic [3:0] s);
      string letters, digits, l1, l2;
      byte   lc, dc;
      letters = "ABCDEFGH";
      digits  = "12345678";
      if (s >= 4'd1 && s <= 4'd8) begin
         lc = letters.getc(int'(s) - 1);
         dc = digits.getc(int'(s) - 1);
      end else begin
         lc = "?";
         dc = "?";
      end
      l1 = $sformatf("TRAFFIC STATE: %c", lc);
      l2 = $sformatf("PHASE %c/8       ", dc);
      want_q.push_back(9'h080);
      for (int unsigned i = 0; i < 16; i++) want_q.push_back({1'b1, 8'(l1.getc(int'(i)))});
      want_q.push_back(9'h0C0);
      for (int unsigned i = 0; i < 16; i++) want_q.push_back({1'b1, 8'(l2.getc(int'(i)))});
   endfunction

   task automatic cmp_q(input string tag);
      chk({tag, "_len"}, 32'(got.size()), 32'(want_q.size()));
      for (int unsigned i = 0; i < want_q.size(); i++)
         if (i < got.size())
            chk($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(want_q[i]));
   endtask

   task automatic wait_busy(input logic lvl, input int lim, input string tag);
      int n;
      n = 0;
      while (busy !== lvl && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(busy), 32'(lvl));
   endtask

   task automatic wait_pulses(input int cnt, input int lim, input string tag);
      int n;
      n = 0;
      while (got.size() < cnt && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(got.size() >= cnt), 32'd1);
   endtask

   task automatic wait_pwr(input string tag);
      int n;
      n = 0;
      while (lcd_e !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n), 32'(INIT_WAIT + SETUP_CYC));
   endtask

   task automatic run_write(input logic [3:0] s);
      string tag;
      tag = $sformatf("wr%0d", s);
      got.delete();
      want_q.delete();
      @(negedge clk);
      state2 = s;
      if (s == shown_m) begin
         repeat (40) @(negedge clk);
         chk({tag, "_none"}, 32'(got.size()), 32'd0);
      end else begin
         push_msg(s);
         wait_busy(1'b1, 5, {tag, "_start"});
         wait_busy(1'b0, int'(34 * BYTE_CYC + 20), {tag, "_end"});
         repeat (3) @(negedge clk);
         cmp_q(tag);
         chk({tag, "_busy_len"}, 32'(last_busy), 32'(34 * BYTE_CYC));
         shown_m = s;
      end
   endtask

   // Bus monitor: records strobed bytes and checks setup, strobe width and hold.
   initial begin
      logic [8:0] cur;
      forever begin
         @(negedge clk);
         cyc++;
         cur = {lcd_rs, lcd_data};
         if (!rst) begin
            pulse_on  = 1'b0;
            prev_fall = -1;
            last_chg  = cyc;
            prev_bus  = cur;
            brun      = 0;
         end else begin
            if (cur != prev_bus) begin
               chk("bus_stable_in_pulse", 32'(pulse_on), 32'd0);
               if (prev_fall >= 0)
                  chk("hold_len_ok", 32'(cyc - prev_fall >= prev_wait), 32'd1);
               last_chg = cyc;
               prev_bus = cur;
            end
            if (lcd_e && !pulse_on) begin
               pulse_on = 1'b1;
               rise_cyc = cyc;
               got.push_back(cur);
               chk("rw_low", 32'(lcd_rw), 32'd0);
               if (last_chg > prev_fall)
                  chk("setup_len", 32'(cyc - last_chg), 32'(SETUP_CYC));
               else
                  chk("gap_len_ok", 32'(cyc - prev_fall >= prev_wait + int'(SETUP_CYC)), 32'd1);
            end else if (!lcd_e && pulse_on) begin
               chk("e_width", 32'(cyc - rise_cyc), 32'(EN_CYC));
               pulse_on  = 1'b0;
               prev_fall = cyc;
               prev_wait = (cur == 9'h001) ? int'(CLR_WAIT) : int'(CMD_WAIT);
            end
            if (busy && ready)
               brun++;
            else begin
               if (brun > 0) last_busy = brun;
               brun = 0;
            end
         end
      end
   end

   initial begin
      logic [3:0] s;
      shown_m = 4'd0;
      rst     = 1'b0;
      state2  = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_e", 32'(lcd_e), 32'd0);
      chk("rst_rs", 32'(lcd_rs), 32'd0);
      chk("rst_rw", 32'(lcd_rw), 32'd0);
      chk("rst_data", 32'(lcd_data), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);

      // Power-up and init with index 0: four commands, no refresh afterwards.
      rst = 1'b1;
      got.delete();
      wait_pwr("pwr_wait");
      begin
         int n;
         n = 0;
         while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
         end
      end
      chk("ready_up", 32'(ready), 32'd1);
      want_q.delete();
      push_init();
      cmp_q("init");
      chk("idle_busy", 32'(busy), 32'd0);
      repeat (20) @(negedge clk);
      chk("no_write_idx0", 32'(got.size()), 32'd4);

      // Directed refreshes, including an out-of-range index.
      run_write(4'd4);
      run_write(4'd9);

      // Index change in the middle of a refresh.
      got.delete();
      want_q.delete();
      push_msg(4'd2);
      push_msg(4'd7);
      @(negedge clk);
      state2 = 4'd2;
      wait_pulses(10, 300, "mid_p10");
      state2 = 4'd7;
      wait_pulses(68, 1200, "mid_p68");
      wait_busy(1'b0, 300, "mid_end");
      repeat (30) @(negedge clk);
      cmp_q("mid");
      shown_m = 4'd7;

      // Stable index: the bus stays quiet.
      got.delete();
      repeat (1000) @(negedge clk);
      chk("hold_quiet", 32'(got.size()), 32'd0);

      // Randomized refreshes; repeats of the shown index must produce nothing.
      for (int unsigned k = 0; k < 6; k++) run_write(4'($urandom_range(0, 15)));

      // Reset during the 20th strobe of a refresh.
      do s = 4'($urandom_range(1, 15)); while (s == shown_m);
      @(negedge clk);
      state2 = s;
      got.delete();
      wait_pulses(20, 400, "rst_p20");
      #1 rst = 1'b0;
      #1;
      chk("arst_e", 32'(lcd_e), 32'd0);
      chk("arst_rs", 32'(lcd_rs), 32'd0);
      chk("arst_data", 32'(lcd_data), 32'd0);
      chk("arst_ready", 32'(ready), 32'd0);
      chk("arst_busy", 32'(busy), 32'd1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      got.delete();
      shown_m = 4'd0;
      want_q.delete();
      push_init();
      push_msg(s);
      wait_pwr("pwr_wait2");
      wait_pulses(38, 1000, "rst_p38");
      wait_busy(1'b0, 400, "rst_end");
      repeat (5) @(negedge clk);
      cmp_q("rst_rw");
      chk("rst_busy_len", 32'(last_busy), 32'(34 * BYTE_CYC));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
